// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with a start/busy/done handshake.
// Both paths work on operand magnitudes; the sign correction is applied on the final step.
module muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int MUL_UNROLL = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int W2 = 2 * XLEN;
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_UNROLL - 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
   state_t state, state_nxt;

   logic [1:0]      fn;
   logic            neg_q, neg_r;
   logic [CW-1:0]   cnt;
   logic [W2-1:0]   acc, mcand;
   logic [XLEN-1:0] mplier;

   logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_res, fin_res;
   logic [W2-1:0]   acc_nxt, prod;
   logic [XLEN:0]   rem_sh, rem_diff;
   logic            accept, last, finish;

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [W2-1:0] neg_w(input logic [W2-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   // Accept-time operand decode; MUL is treated as signed since its low half is sign-agnostic
   always_comb begin
      a_sgn   = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
      b_sgn   = a_sgn && (funct3 != 3'b010);
      a_neg   = a_sgn && op_a[XLEN-1];
      b_neg   = b_sgn && op_b[XLEN-1];
      a_mag   = neg_x(op_a, a_neg);
      b_mag   = neg_x(op_b, b_neg);
      b_zero  = (op_b == '0);
      ovf     = funct3[2] && !funct3[0] && (op_a == XMIN) && (&op_b);
      special = funct3[2] && (b_zero || ovf);
      if (b_zero) spec_res = funct3[1] ? op_a : '1;
      else        spec_res = funct3[1] ? '0 : op_a;
   end

   // One iteration step: acc is the product for MUL, {remainder, quotient} for DIV
   always_comb begin
      acc_nxt  = acc;
      rem_sh   = acc[W2-1:XLEN-1];
      rem_diff = rem_sh - {1'b0, mcand[XLEN-1:0]};
      if (state == S_MUL) begin
         for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier[i]) acc_nxt = acc_nxt + (mcand << i);
         end
      end else if (!rem_diff[XLEN]) begin
         acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
      prod = neg_w(acc_nxt, neg_q);
      if (state == S_MUL) fin_res = (fn == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
      else if (fn[1])     fin_res = neg_x(acc_nxt[W2-1:XLEN], neg_r);
      else                fin_res = neg_x(acc_nxt[XLEN-1:0], neg_q);
   end

   assign last = (cnt == ((state == S_MUL) ? MUL_LAST : DIV_LAST));
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // The last iteration edge applies the sign fix and raises done, so done lands on an idle cycle
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               accept = 1'b1;
               if (!special) state_nxt = funct3[2] ? S_DIV : S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            if (flush) begin
               state_nxt = S_IDLE;
            end else if (last) begin
               finish    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            fn     <= funct3[1:0];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            mplier <= b_mag;
            if (funct3[2]) begin
               acc   <= {{XLEN{1'b0}}, a_mag};
               mcand <= {{XLEN{1'b0}}, b_mag};
            end else begin
               acc   <= '0;
               mcand <= {{XLEN{1'b0}}, a_mag};
            end
            if (special) begin
               result <= spec_res;
               done   <= 1'b1;
            end
         end else if (busy && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (state == S_MUL) begin
               mcand  <= mcand << MUL_UNROLL;
               mplier <= mplier >> MUL_UNROLL;
            end
            if (finish) begin
               result <= fin_res;
               done   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit at XLEN=32, MUL_UNROLL=4.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          cyc;
   } vec_t;

   vec_t vecs[20];
   int   cyc, cyc2, ndone, saw_done, busy_late;

   muldiv_unit #(.XLEN(32), .MUL_UNROLL(4)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .flush(flush),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
   endtask

   // Returns the cycle (accept = 0) on which done was seen, or 0 on timeout
   task automatic wait_done(input int maxc, output int c);
      c = 0;
      for (int k = 1; k <= maxc && c == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start  = 1'b0;
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
         end
         if (done === 1'b1) c = k;
      end
   endtask

   initial begin
      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9};
      vecs[2]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 9};
      vecs[3]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9};
      vecs[4]  = '{3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33};
      vecs[5]  = '{3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33};
      vecs[6]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[9]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
      vecs[10] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
      vecs[11] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
      vecs[12] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 9};
      vecs[13] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 9};
      vecs[14] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9};
      vecs[15] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[16] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[17] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      vecs[18] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33};
      vecs[19] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9};

      reset  = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      op_a   = '0;
      op_b   = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b);
         wait_done(60, cyc);
         chk($sformatf("v%0d_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_result", i), result, vecs[i].exp);
         chk($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
      end

      // Flush mid-divide: no done, result keeps the previous value
      issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
      wait_done(60, cyc);
      chk("pre_flush_result", result, 32'hFFFF_FFEB);
      @(negedge clk);
      issue(3'b101, 32'd100, 32'd7);
      saw_done = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done === 1'b1) saw_done = 1;
         if (k == 10) begin
            chk("flush_busy_before", {31'b0, busy}, 32'd1);
            flush = 1'b1;
         end
         if (k == 11) begin
            flush = 1'b0;
            chk("flush_busy_after", {31'b0, busy}, 32'd0);
         end
      end
      chk("flush_no_done", 32'(saw_done), 32'd0);
      chk("flush_result_kept", result, 32'hFFFF_FFEB);

      // start together with flush in idle is not accepted
      issue(3'b101, 32'd5, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk("startflush_busy", {31'b0, busy}, 32'd0);
      chk("startflush_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      chk("startflush_done2", {31'b0, done}, 32'd0);

      issue(3'b101, 32'd100, 32'd7);
      wait_done(60, cyc);
      chk("restart_cycle", 32'(cyc), 32'd33);
      chk("restart_result", result, 32'd14);
      @(negedge clk);

      // Back-to-back: new start in the done cycle; a start while busy is dropped
      issue(3'b000, 32'd3, 32'd5);
      wait_done(60, cyc);
      chk("b2b_first_cycle", 32'(cyc), 32'd9);
      chk("b2b_first_result", result, 32'd15);
      issue(3'b000, 32'd6, 32'd7);
      cyc2 = 0;
      ndone = 0;
      busy_late = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            chk("b2b_accepted", {31'b0, busy}, 32'd1);
         end
         if (k == 3) issue(3'b100, 32'd100, 32'd0);
         if (k == 4) start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (cyc2 == 0) cyc2 = k;
         end
         if (k >= 10 && busy === 1'b1) busy_late = 1;
      end
      chk("b2b_second_cycle", 32'(cyc2), 32'd9);
      chk("b2b_second_result", result, 32'd42);
      chk("b2b_done_count", 32'(ndone), 32'd1);
      chk("b2b_not_queued", 32'(busy_late), 32'd0);

      // Asynchronous reset in the middle of a divide
      issue(3'b101, 32'd100, 32'd7);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      chk("areset_busy_before", {31'b0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("areset_busy", {31'b0, busy}, 32'd0);
      chk("areset_result", result, 32'd0);
      chk("areset_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("areset_no_done", 32'(ndone), 32'd0);
      chk("areset_result_held", result, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
